// File: rtl/hbmc_pkg.sv
// Shared sizing helpers for the HBMC datapath blocks.
package hbmc_pkg;

   function automatic int hbmc_level_width(input int addr_width);
      return addr_width + 1;
   endfunction

   // The output register, when present, holds one word beyond the RAM depth.
   function automatic int hbmc_capacity(input int addr_width, input int out_reg);
      return (1 << addr_width) + out_reg;
   endfunction

endpackage

// File: rtl/hbmc_dpram_dist.sv
// Distributed dual-port RAM: synchronous write port, asynchronous read port.
module hbmc_dpram_dist #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // No reset on the array so it maps onto LUT RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hbmc_stream_fifo.sv
// Single-clock first-word-fall-through stream FIFO on distributed RAM, with an
// optional output register, occupancy flags and synchronous flush.
module hbmc_stream_fifo
   import hbmc_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDR_WIDTH    = 5,
   parameter int OUT_REG       = 1,
   parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                                    clk,
   input  logic                                    arstn,
   input  logic                                    flush,
   input  logic [DATA_WIDTH-1:0]                   s_tdata,
   input  logic                                    s_tvalid,
   output logic                                    s_tready,
   output logic [DATA_WIDTH-1:0]                   m_tdata,
   output logic                                    m_tvalid,
   input  logic                                    m_tready,
   output logic [hbmc_level_width(ADDR_WIDTH)-1:0] level,
   output logic                                    almost_full,
   output logic                                    almost_empty
);

   localparam int LW  = hbmc_level_width(ADDR_WIDTH);
   localparam int CAP = hbmc_capacity(ADDR_WIDTH, OUT_REG);

   localparam logic [LW-1:0]       LVL_ONE    = LW'(1);
   localparam logic [LW-1:0]       CAP_LVL    = LW'(CAP);
   localparam logic [LW-1:0]       AFULL_LVL  = LW'(AFULL_THRESH);
   localparam logic [LW-1:0]       AEMPTY_LVL = LW'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);

   if (AFULL_THRESH < 1 || AFULL_THRESH > CAP ||
       AEMPTY_THRESH < 0 || AEMPTY_THRESH > CAP - 1) begin : g_bad_thresh
      $error("hbmc_stream_fifo: almost-full/almost-empty threshold out of range");
   end

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  push;
   logic                  pop;
   logic                  ram_we;
   logic                  ram_rd;
   logic                  ram_empty;
   logic                  ram_full;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [LW-1:0]         level_nxt;

   // Flush wins over both handshakes in the same cycle.
   assign push = s_tvalid & s_tready & ~flush;
   assign pop  = m_tvalid & m_tready & ~flush;

   assign ram_empty = (wr_ptr == rd_ptr);
   assign ram_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign ram_we    = push & ~ram_full;

   hbmc_dpram_dist #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (s_tdata),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (ram_we) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (ram_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_comb begin
      level_nxt = level;
      if (flush) begin
         level_nxt = '0;
      end else if (push && !pop) begin
         level_nxt = level + LVL_ONE;
      end else if (!push && pop) begin
         level_nxt = level - LVL_ONE;
      end
   end

   // Ready and flags come from the next level so they move on the same edge as
   // the count; ready drops for one cycle after a flush, as after reset.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         level        <= '0;
         s_tready     <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         level        <= level_nxt;
         s_tready     <= ~flush && (level_nxt < CAP_LVL);
         almost_full  <= (level_nxt >= AFULL_LVL);
         almost_empty <= (level_nxt <= AEMPTY_LVL);
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic                  load;
      logic [DATA_WIDTH-1:0] out_data;

      // Refill whenever the register is empty or its word leaves this cycle.
      assign load    = ~flush & ~ram_empty & (~m_tvalid | m_tready);
      assign ram_rd  = load;
      assign m_tdata = out_data;

      always_ff @(posedge clk or negedge arstn) begin
         if (!arstn) begin
            m_tvalid <= 1'b0;
            out_data <= '0;
         end else if (flush) begin
            m_tvalid <= 1'b0;
         end else if (load) begin
            m_tvalid <= 1'b1;
            out_data <= ram_rdata;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end else begin : g_no_out_reg
      assign ram_rd  = pop;
      assign m_tdata = ram_rdata;

      always_ff @(posedge clk or negedge arstn) begin
         if (!arstn) begin
            m_tvalid <= 1'b0;
         end else begin
            m_tvalid <= (level_nxt != '0);
         end
      end
   end

endmodule

// File: tb/tb_hbmc_stream_fifo.sv
// Directed bench: a 32-deep FIFO with output register plus an 8-deep FIFO
// without one, both fed from the same stimulus.
module tb_hbmc_stream_fifo;

   logic        clk = 1'b0;
   logic        arstn = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        m_tready = 1'b0;

   logic        s_tready;
   logic [15:0] m_tdata;
   logic        m_tvalid;
   logic [5:0]  level;
   logic        almost_full;
   logic        almost_empty;

   logic        s_tready_0;
   logic [15:0] m_tdata_0;
   logic        m_tvalid_0;
   logic [3:0]  level_0;
   logic        almost_full_0;
   logic        almost_empty_0;

   int check_count = 0;
   int error_count = 0;

   always #5 clk = ~clk;

   hbmc_stream_fifo #(
      .DATA_WIDTH    (16),
      .ADDR_WIDTH    (5),
      .OUT_REG       (1),
      .AFULL_THRESH  (29),
      .AEMPTY_THRESH (2)
   ) u_dut (
      .clk          (clk),
      .arstn        (arstn),
      .flush        (flush),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tready     (s_tready),
      .m_tdata      (m_tdata),
      .m_tvalid     (m_tvalid),
      .m_tready     (m_tready),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   hbmc_stream_fifo #(
      .DATA_WIDTH    (16),
      .ADDR_WIDTH    (3),
      .OUT_REG       (0),
      .AFULL_THRESH  (4),
      .AEMPTY_THRESH (2)
   ) u_dut0 (
      .clk          (clk),
      .arstn        (arstn),
      .flush        (flush),
      .s_tdata      (s_tdata),
      .s_tvalid     (s_tvalid),
      .s_tready     (s_tready_0),
      .m_tdata      (m_tdata_0),
      .m_tvalid     (m_tvalid_0),
      .m_tready     (m_tready),
      .level        (level_0),
      .almost_full  (almost_full_0),
      .almost_empty (almost_empty_0)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then step to 1 time unit past the next edge.
   task automatic applyStimulus(input logic vld, input logic [15:0] data,
                                input logic rdy, input logic fl);
      s_tvalid = vld;
      s_tdata  = data;
      m_tready = rdy;
      flush    = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int tx;
      int rx;
      logic rdy;
      logic vld;
      logic acc;
      logic [15:0] exp_word;

      // Reset held for 5 cycles, outputs at reset values throughout.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("rst_s_tready", 32'(s_tready), 32'd0);
         checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
         checkOutput("rst_level", 32'(level), 32'd0);
         checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
      end
      checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
      checkOutput("rst_m_tdata", 32'(m_tdata), 32'd0);
      arstn = 1'b1;
      #1;
      checkOutput("rel_s_tready_before_edge", 32'(s_tready), 32'd0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("rel_s_tready", 32'(s_tready), 32'd1);
      checkOutput("rel_m_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("rel_level", 32'(level), 32'd0);

      // Fill to full: 33 words accepted, almost_full from level 29.
      for (int i = 0; i < 33; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
         checkOutput("fill_level", 32'(level), 32'(i + 1));
         checkOutput("fill_s_tready", 32'(s_tready), 32'((i + 1) < 33));
         checkOutput("fill_almost_full", 32'(almost_full), 32'((i + 1) >= 29));
         checkOutput("fill_almost_empty", 32'(almost_empty), 32'((i + 1) <= 2));
      end
      applyStimulus(1'b1, 16'h0021, 1'b0, 1'b0);
      checkOutput("full_refuse_level", 32'(level), 32'd33);
      checkOutput("full_refuse_s_tready", 32'(s_tready), 32'd0);
      checkOutput("full_head_valid", 32'(m_tvalid), 32'd1);
      checkOutput("full_head_data", 32'(m_tdata), 32'h0000);
      checkOutput("full0_level", 32'(level_0), 32'd8);
      checkOutput("full0_s_tready", 32'(s_tready_0), 32'd0);
      checkOutput("full0_almost_full", 32'(almost_full_0), 32'd1);
      checkOutput("full0_head_data", 32'(m_tdata_0), 32'h0000);

      // Full with simultaneous pop: push refused, ready returns next edge.
      applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0);
      checkOutput("fullpop_level", 32'(level), 32'd32);
      checkOutput("fullpop_s_tready", 32'(s_tready), 32'd1);
      checkOutput("fullpop_head_data", 32'(m_tdata), 32'h0001);
      checkOutput("fullpop0_level", 32'(level_0), 32'd7);
      checkOutput("fullpop0_head_data", 32'(m_tdata_0), 32'h0001);
      applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
      checkOutput("fullpop_retry_level", 32'(level), 32'd33);
      checkOutput("fullpop_retry_s_tready", 32'(s_tready), 32'd0);
      checkOutput("fullpop0_retry_level", 32'(level_0), 32'd8);

      // Drain: 1..32 then 0x100 (8-deep copy: 1..7 then 0x100).
      for (int i = 0; i < 33; i++) begin
         exp_word = (i < 32) ? 16'(i + 1) : 16'h0100;
         checkOutput("drain_valid", 32'(m_tvalid), 32'd1);
         checkOutput("drain_data", 32'(m_tdata), 32'(exp_word));
         if (i < 8) begin
            exp_word = (i < 7) ? 16'(i + 1) : 16'h0100;
            checkOutput("drain0_valid", 32'(m_tvalid_0), 32'd1);
            checkOutput("drain0_data", 32'(m_tdata_0), 32'(exp_word));
         end
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      end
      checkOutput("drained_level", 32'(level), 32'd0);
      checkOutput("drained_m_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("drained_almost_empty", 32'(almost_empty), 32'd1);
      checkOutput("drained0_level", 32'(level_0), 32'd0);
      checkOutput("drained0_almost_empty", 32'(almost_empty_0), 32'd1);

      // 100 sequential words with random consumer back-pressure.
      tx = 0;
      rx = 0;
      for (int cyc = 0; cyc < 3000 && rx < 100; cyc++) begin
         rdy = 1'($urandom_range(0, 1));
         vld = (tx < 100);
         if (m_tvalid && rdy) begin
            checkOutput("rand_word", 32'(m_tdata), 32'(rx));
            rx++;
         end
         acc = vld && s_tready;
         applyStimulus(vld, 16'(tx), rdy, 1'b0);
         if (acc) tx++;
      end
      checkOutput("rand_rx_count", 32'(rx), 32'd100);
      checkOutput("rand_end_level", 32'(level), 32'd0);

      // Flush clears both copies; ready low for one cycle afterwards.
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("flush0_s_tready_low", 32'(s_tready), 32'd0);
      checkOutput("flush0_level0", 32'(level_0), 32'd0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("flush0_s_tready_back", 32'(s_tready), 32'd1);

      // Latency: visible after edge N without output register, N+1 with it.
      applyStimulus(1'b1, 16'hA5A5, 1'b0, 1'b0);
      checkOutput("lat_n_m_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("lat_n_level", 32'(level), 32'd1);
      checkOutput("lat0_n_m_tvalid", 32'(m_tvalid_0), 32'd1);
      checkOutput("lat0_n_m_tdata", 32'(m_tdata_0), 32'hA5A5);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("lat_n1_m_tvalid", 32'(m_tvalid), 32'd1);
      checkOutput("lat_n1_m_tdata", 32'(m_tdata), 32'hA5A5);

      // Flush with 10 words held and a push in the flush cycle.
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
      end
      checkOutput("preflush_level", 32'(level), 32'd10);
      applyStimulus(1'b1, 16'h3333, 1'b0, 1'b1);
      checkOutput("flush_level", 32'(level), 32'd0);
      checkOutput("flush_m_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("flush_almost_empty", 32'(almost_empty), 32'd1);
      checkOutput("flush_almost_full", 32'(almost_full), 32'd0);
      checkOutput("flush_s_tready", 32'(s_tready), 32'd0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("postflush_s_tready", 32'(s_tready), 32'd1);
      checkOutput("postflush_level", 32'(level), 32'd0);
      applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("postflush_m_tvalid", 32'(m_tvalid), 32'd1);
      checkOutput("postflush_m_tdata", 32'(m_tdata), 32'h1234);
      checkOutput("postflush_level1", 32'(level), 32'd1);

      // Async reset in the middle of a push/pop burst.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 16'(16'h4000 + i), 1'b1, 1'b0);
      end
      checkOutput("burst_m_tvalid", 32'(m_tvalid), 32'd1);
      checkOutput("burst_m_tdata", 32'(m_tdata), 32'h4001);
      checkOutput("burst_level", 32'(level), 32'd2);
      #2;
      arstn = 1'b0;
      #1;
      checkOutput("arst_s_tready", 32'(s_tready), 32'd0);
      checkOutput("arst_m_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("arst_m_tdata", 32'(m_tdata), 32'd0);
      checkOutput("arst_level", 32'(level), 32'd0);
      checkOutput("arst_almost_empty", 32'(almost_empty), 32'd1);
      checkOutput("arst_almost_full", 32'(almost_full), 32'd0);
      checkOutput("arst0_level", 32'(level_0), 32'd0);
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      @(posedge clk);
      #1;
      arstn = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("rearm_s_tready", 32'(s_tready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
